// File: rtl/vec_pkg.sv
// Shared widths and opcodes for the vector register file ALU.
package vec_pkg;

    localparam int LANE_W = 32;
    localparam int LANES  = 16;
    localparam int VEC_W  = LANE_W * LANES;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_STORE = 2'b01;
    localparam logic [1:0] OP_ADD   = 2'b10;
    localparam logic [1:0] OP_MUL   = 2'b11;

endpackage

// File: rtl/alu_if.sv
// Register file <-> ALU bus: the four source vectors, opcode and the two write-back vectors.
interface alu_if;
    import vec_pkg::*;

    logic [VEC_W-1:0] A1;
    logic [VEC_W-1:0] A2;
    logic [VEC_W-1:0] A3;
    logic [VEC_W-1:0] A4;
    logic [1:0]       op;
    logic [VEC_W-1:0] write_on_A3;
    logic [VEC_W-1:0] write_on_A4;

    // register file side
    modport master (
        output A1, A2, A3, A4, op,
        input  write_on_A3, write_on_A4
    );

    // ALU side
    modport slave (
        input  A1, A2, A3, A4, op,
        output write_on_A3, write_on_A4
    );

endinterface

// File: rtl/alu_lane.sv
// One combinational SIMD lane: signed add or full signed multiply, double-width result.
module alu_lane
    import vec_pkg::*;
(
    input  logic [LANE_W-1:0]   a,
    input  logic [LANE_W-1:0]   b,
    input  logic [1:0]          op,
    output logic [2*LANE_W-1:0] res
);

    // Sign-extend once; a 64-bit product of the extended operands is the exact
    // signed product, and the 64-bit sum carries the sign/carry into the high half.
    logic signed [2*LANE_W-1:0] a_x;
    logic signed [2*LANE_W-1:0] b_x;

    assign a_x = {{LANE_W{a[LANE_W-1]}}, a};
    assign b_x = {{LANE_W{b[LANE_W-1]}}, b};

    // Select the arithmetic result; load/store results are unused by the top.
    always_comb begin
        res = '0;
        case (op)
            OP_ADD:  res = a_x + b_x;
            OP_MUL:  res = a_x * b_x;
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered 512-bit SIMD ALU: 16 independent lanes, low halves to A3, high halves to A4.
module alu
    import vec_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    alu_if.slave  bus
);

    logic [LANES-1:0][LANE_W-1:0]   a1_l;
    logic [LANES-1:0][LANE_W-1:0]   a2_l;
    logic [LANES-1:0][2*LANE_W-1:0] lane_res;
    logic [LANES-1:0][LANE_W-1:0]   nxt_lo;
    logic [LANES-1:0][LANE_W-1:0]   nxt_hi;
    logic [VEC_W-1:0]               a3_q;
    logic [VEC_W-1:0]               a4_q;
    logic                           is_arith;

    assign a1_l     = bus.A1;
    assign a2_l     = bus.A2;
    assign is_arith = (bus.op == OP_ADD) || (bus.op == OP_MUL);

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        alu_lane u_lane (
            .a   (a1_l[i]),
            .b   (a2_l[i]),
            .op  (bus.op),
            .res (lane_res[i])
        );
    end

    // Split lane results into low/high halves, or pass A3/A4 through so a stray
    // write-back on load/store leaves the registers unchanged.
    always_comb begin
        nxt_lo = bus.A3;
        nxt_hi = bus.A4;
        if (is_arith) begin
            for (int i = 0; i < LANES; i++) begin
                nxt_lo[i] = lane_res[i][LANE_W-1:0];
                nxt_hi[i] = lane_res[i][2*LANE_W-1:LANE_W];
            end
        end
    end

    // Output registers, cleared asynchronously while rst is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a3_q <= '0;
            a4_q <= '0;
        end else begin
            a3_q <= nxt_lo;
            a4_q <= nxt_hi;
        end
    end

    assign bus.write_on_A3 = a3_q;
    assign bus.write_on_A4 = a4_q;

endmodule

// File: tb/tb_alu.sv
// Directed bench for the vector ALU: reset, add, mul, corners, pass-through, op switch.
module tb_alu;
    import vec_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [VEC_W-1:0] exp_lo;
    logic [VEC_W-1:0] exp_hi;
    logic [31:0]      ra;
    logic [31:0]      rb;
    longint           pr;

    alu_if bus ();

    alu dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VEC_W-1:0] rep(input logic [31:0] v);
        return {LANES{v}};
    endfunction

    task automatic check(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // advance one rising edge and settle past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        bus.A1 = '0;
        bus.A2 = '0;
        bus.A3 = '0;
        bus.A4 = '0;
        bus.op = OP_LOAD;

        // reset state
        #1;
        check("reset_a3", bus.write_on_A3, '0);
        check("reset_a4", bus.write_on_A4, '0);
        @(negedge clk);
        rst = 1'b1;

        // add 5 + 7
        bus.A1 = rep(32'd5);
        bus.A2 = rep(32'd7);
        bus.op = OP_ADD;
        step();
        check("add_pos_a3", bus.write_on_A3, rep(32'd12));
        check("add_pos_a4", bus.write_on_A4, '0);

        // add -3 + 1 -> -2, high half all ones
        bus.A1 = rep(32'hFFFF_FFFD);
        bus.A2 = rep(32'd1);
        step();
        check("add_neg_a3", bus.write_on_A3, rep(32'hFFFF_FFFE));
        check("add_neg_a4", bus.write_on_A4, rep(32'hFFFF_FFFF));

        // mul: lane0 2^16*2^16, lane1 -2*3
        bus.A1 = '0;
        bus.A2 = '0;
        bus.A1[31:0]  = 32'h0001_0000;
        bus.A2[31:0]  = 32'h0001_0000;
        bus.A1[63:32] = 32'hFFFF_FFFE;
        bus.A2[63:32] = 32'd3;
        bus.op = OP_MUL;
        step();
        check32("mul_l0_a3", bus.write_on_A3[31:0], 32'h0);
        check32("mul_l0_a4", bus.write_on_A4[31:0], 32'h1);
        check32("mul_l1_a3", bus.write_on_A3[63:32], 32'hFFFF_FFFA);
        check32("mul_l1_a4", bus.write_on_A4[63:32], 32'hFFFF_FFFF);

        // corner: -2^31 * -2^31 = 2^62
        bus.A1 = rep(32'h8000_0000);
        bus.A2 = rep(32'h8000_0000);
        step();
        check("mul_min_a3", bus.write_on_A3, '0);
        check("mul_min_a4", bus.write_on_A4, rep(32'h4000_0000));

        // mixed random vector against a 64-bit signed reference
        for (int i = 0; i < LANES; i++) begin
            ra = $urandom;
            rb = $urandom;
            bus.A1[32*i +: 32] = ra;
            bus.A2[32*i +: 32] = rb;
            pr = longint'($signed(ra)) * longint'($signed(rb));
            exp_lo[32*i +: 32] = pr[31:0];
            exp_hi[32*i +: 32] = pr[63:32];
        end
        step();
        check("mul_rand_a3", bus.write_on_A3, exp_lo);
        check("mul_rand_a4", bus.write_on_A4, exp_hi);

        // pass-through on load then store
        bus.A3 = rep(32'hAAAA_AAAA);
        bus.A4 = rep(32'h5555_5555);
        bus.op = OP_LOAD;
        step();
        check("load_a3", bus.write_on_A3, rep(32'hAAAA_AAAA));
        check("load_a4", bus.write_on_A4, rep(32'h5555_5555));
        bus.A3 = rep(32'h1234_5678);
        bus.op = OP_STORE;
        step();
        check("store_a3", bus.write_on_A3, rep(32'h1234_5678));
        check("store_a4", bus.write_on_A4, rep(32'h5555_5555));

        // op switch add -> mul with distinct per-lane values (lane i: A1=i+1, A2=2)
        for (int i = 0; i < LANES; i++) begin
            bus.A1[32*i +: 32] = 32'(i + 1);
            bus.A2[32*i +: 32] = 32'd2;
            exp_lo[32*i +: 32] = 32'(i + 3);
        end
        bus.op = OP_ADD;
        step();
        check("switch_add_a3", bus.write_on_A3, exp_lo);
        check("switch_add_a4", bus.write_on_A4, '0);
        for (int i = 0; i < LANES; i++) exp_lo[32*i +: 32] = 32'(2 * i + 2);
        bus.op = OP_MUL;
        step();
        check("switch_mul_a3", bus.write_on_A3, exp_lo);
        check("switch_mul_a4", bus.write_on_A4, '0);

        // async reset mid-cycle with nonzero outputs
        #2;
        rst = 1'b0;
        #1;
        check("async_rst_a3", bus.write_on_A3, '0);
        check("async_rst_a4", bus.write_on_A4, '0);
        step();
        check("held_rst_a3", bus.write_on_A3, '0);
        check("held_rst_a4", bus.write_on_A4, '0);
        bus.A1 = rep(32'd100);
        bus.A2 = rep(32'hFFFF_FF38); // -200
        bus.op = OP_ADD;
        #2;
        rst = 1'b1;
        #1;
        check("release_no_edge_a3", bus.write_on_A3, '0);
        step();
        check("post_rst_a3", bus.write_on_A3, rep(32'hFFFF_FF9C));
        check("post_rst_a4", bus.write_on_A4, rep(32'hFFFF_FFFF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
